fetch_controller: RTL and testbench

- Instruction fetch sequencer for the CPU.
- Owns the program counter and drives the combinational instruction memory's byte address: one word per cycle, word-aligned, memory indexed by Address[$clog2(MEM_DEPTH)+1:2].
- Buffers fetched {PC, instruction} pairs in a small FIFO with a valid/ready handshake to decode.
- Handles redirects from the branch/jump resolution stage and halts at end of memory.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 59 +++++
 rtl/fetch_controller.sv | 133 +++++++++++++
 tb/tb_fetch_controller.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: instruction field positions, opcodes, fetch FSM encoding.
// No logic, no latency, no backpressure.
package cpu_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int IMM_MSB = 11;
    localparam int IMM_LSB = 0;

    localparam logic [OPC_MSB-OPC_LSB:0] OPC_JUMP = 5'b10010;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with push, pop and flush; flush beats push.
// Latency: a pushed entry is at the head after the clock edge; push when full only lands with a same-cycle pop.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_dat_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns PC, fetches one word per cycle into a {PC, instr} buffer for decode.
// Latency: word fetched in cycle N is at the head after edge N; fetch stalls while the buffer is full and not popped.
// Optional FETCH_EARLY_JUMP_EN: JUMP opcodes redirect the PC at fetch time.
module fetch_controller
    import cpu_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          MEM_DEPTH  = 256,
    parameter int          FIFO_DEPTH = 2,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Start,
    output logic [DATA_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] Instruction,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    output logic [DATA_WIDTH-1:0] Out_Instruction,
    output logic [DATA_WIDTH-1:0] Out_PC,
    input  logic                  Redirect_Valid,
    input  logic [DATA_WIDTH-1:0] Redirect_Target,
    output logic                  Halted,
    output logic                  Fault
);

    localparam logic [DATA_WIDTH-1:0] LAST_ADDR = DATA_WIDTH'(4 * MEM_DEPTH - 4);
    localparam logic [DATA_WIDTH-1:0] MEM_WORDS = DATA_WIDTH'(MEM_DEPTH);

    fetch_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0]   pc_q, pc_d;
    logic                    fault_q, fault_d;
    logic                    halted_q;
    logic                    push, pop, flush;
    logic                    fifo_full, fifo_empty;
    logic [2*DATA_WIDTH-1:0] head_dat;
    logic                    redir_oor;

    assign redir_oor = ({2'b00, Redirect_Target[DATA_WIDTH-1:2]} >= MEM_WORDS);

`ifdef FETCH_EARLY_JUMP_EN
    logic                  is_jump;
    logic                  jump_oor;
    logic [DATA_WIDTH-1:0] jump_target;

    assign is_jump     = (Instruction[OPC_MSB:OPC_LSB] == OPC_JUMP);
    assign jump_target = {{(DATA_WIDTH-(IMM_MSB-IMM_LSB+3)){1'b0}}, Instruction[IMM_MSB:IMM_LSB], 2'b00};
    assign jump_oor    = ({{(DATA_WIDTH-(IMM_MSB-IMM_LSB+1)){1'b0}}, Instruction[IMM_MSB:IMM_LSB]} >= MEM_WORDS);
`endif

    assign Address   = pc_q;
    assign Out_Valid = !fifo_empty;
    assign pop       = Out_Valid && Out_Ready;
    assign Out_PC          = head_dat[2*DATA_WIDTH-1:DATA_WIDTH];
    assign Out_Instruction = head_dat[DATA_WIDTH-1:0];
    assign Halted    = halted_q;
    assign Fault     = fault_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        push    = 1'b0;
        flush   = 1'b0;
        if (Redirect_Valid) begin
            flush = 1'b1;
            if (redir_oor) begin
                state_d = FETCH_HALT;
                fault_d = 1'b1;
            end else begin
                pc_d    = {Redirect_Target[DATA_WIDTH-1:2], 2'b00};
                state_d = FETCH_RUN;
            end
        end else begin
            case (state_q)
                FETCH_IDLE: if (Start) state_d = FETCH_RUN;
                FETCH_RUN: begin
                    if (!fifo_full || pop) begin
                        push = 1'b1;
                        if (pc_q == LAST_ADDR) state_d = FETCH_HALT;
                        else                   pc_d    = pc_q + DATA_WIDTH'(4);
`ifdef FETCH_EARLY_JUMP_EN
                        // A JUMP overrides both sequential increment and end-of-memory halt.
                        if (is_jump) begin
                            if (jump_oor) begin
                                push    = 1'b0;
                                flush   = 1'b1;
                                pc_d    = pc_q;
                                state_d = FETCH_HALT;
                                fault_d = 1'b1;
                            end else begin
                                pc_d    = jump_target;
                                state_d = FETCH_RUN;
                            end
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FETCH_IDLE;
            pc_q     <= DATA_WIDTH'(RESET_PC);
            fault_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            fault_q  <= fault_d;
            halted_q <= (state_d == FETCH_HALT);
        end
    end

    fetch_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_dat_i ({pc_q, Instruction}),
        .pop_i      (pop),
        .flush_i    (flush),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_dat_o (head_dat)
    );

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: reset, streaming, stall, flush, end-of-memory halt, fault, early jump.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        Start;
    logic [31:0] Address;
    logic [31:0] Instruction;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Out_Instruction;
    logic [31:0] Out_PC;
    logic        Redirect_Valid;
    logic [31:0] Redirect_Target;
    logic        Halted;
    logic        Fault;

    logic [31:0] mem [256];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    assign Instruction = mem[Address[9:2]];

    fetch_controller dut (
        .clk             (clk),
        .rst             (rst),
        .Start           (Start),
        .Address         (Address),
        .Instruction     (Instruction),
        .Out_Valid       (Out_Valid),
        .Out_Ready       (Out_Ready),
        .Out_Instruction (Out_Instruction),
        .Out_PC          (Out_PC),
        .Redirect_Valid  (Redirect_Valid),
        .Redirect_Target (Redirect_Target),
        .Halted          (Halted),
        .Fault           (Fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        Redirect_Valid  = 1'b1;
        Redirect_Target = tgt;
        tick();
        Redirect_Valid  = 1'b0;
        Redirect_Target = 32'h0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        chk("rst_valid", 32'(Out_Valid), 32'h0);
        chk("rst_pc", Out_PC, 32'h0);
        chk("rst_fault", 32'(Fault), 32'h0);
        chk("rst_halted", 32'(Halted), 32'h0);
        chk("rst_addr", Address, 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = {8'hA0, 8'(i), 8'h5A, ~8'(i)};
        end
        mem[27] = 32'h9000_0023;

        rst             = 1'b1;
        Start           = 1'b0;
        Out_Ready       = 1'b0;
        Redirect_Valid  = 1'b0;
        Redirect_Target = 32'h0;
        #2;
        chk("reset_instr", Out_Instruction, 32'h0);
        chk("reset_pc", Out_PC, 32'h0);
        chk("reset_valid", 32'(Out_Valid), 32'h0);
        chk("reset_fault", 32'(Fault), 32'h0);
        rst = 1'b0;

        // Idle with no Start: nothing fetched.
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("idle_addr", Address, 32'h0);
            chk("idle_valid", 32'(Out_Valid), 32'h0);
            chk("idle_halted", 32'(Halted), 32'h0);
        end

        // Streaming with Out_Ready high.
        Start     = 1'b1;
        Out_Ready = 1'b1;
        tick();
        Start = 1'b0;
        chk("start_valid0", 32'(Out_Valid), 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("stream_valid", 32'(Out_Valid), 32'h1);
            chk("stream_pc", Out_PC, 32'(4 * k));
            chk("stream_instr", Out_Instruction, mem[k]);
        end

        // Stall: two entries buffered, fetch stops at 8.
        pulse_reset();
        Out_Ready = 1'b0;
        Start     = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        tick();
        tick();
        chk("stall_addr", Address, 32'h8);
        chk("stall_pc", Out_PC, 32'h0);
        chk("stall_instr", Out_Instruction, mem[0]);
        tick();
        chk("stall_addr2", Address, 32'h8);
        chk("stall_pc2", Out_PC, 32'h0);
        Out_Ready = 1'b1;
        #1;
        chk("drain_pc0", Out_PC, 32'h0);
        tick();
        chk("drain_pc4", Out_PC, 32'h4);
        tick();
        chk("drain_pc8", Out_PC, 32'h8);
        chk("drain_addr", Address, 32'h10);

        // Flush via redirect while full of PC 8/12.
        Out_Ready = 1'b0;
        redirect(32'h8D);
        chk("flush_valid", 32'(Out_Valid), 32'h0);
        chk("flush_addr", Address, 32'h8C);
        Out_Ready = 1'b1;
        tick();
        chk("flush_pc", Out_PC, 32'h8C);
        chk("flush_instr", Out_Instruction, mem[35]);
        tick();
        chk("flush_pc_next", Out_PC, 32'h90);

        // End of memory.
        Out_Ready = 1'b0;
        redirect(32'h3FC);
        chk("eom_addr", Address, 32'h3FC);
        chk("eom_valid0", 32'(Out_Valid), 32'h0);
        tick();
        chk("eom_pc", Out_PC, 32'h3FC);
        chk("eom_instr", Out_Instruction, mem[255]);
        chk("eom_addr_hold", Address, 32'h3FC);
        tick();
        chk("halt_flag", 32'(Halted), 32'h1);
        chk("halt_valid", 32'(Out_Valid), 32'h1);
        chk("halt_pc_hold", Out_PC, 32'h3FC);
        Out_Ready = 1'b1;
        tick();
        chk("halt_drained", 32'(Out_Valid), 32'h0);
        chk("halt_empty_pc", Out_PC, 32'h0);
        tick();
        chk("halt_no_push", 32'(Out_Valid), 32'h0);
        chk("halt_addr", Address, 32'h3FC);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("halt_start_ignored", 32'(Halted), 32'h1);

        // Out-of-range redirect.
        redirect(32'h400);
        chk("oor_fault", 32'(Fault), 32'h1);
        chk("oor_halted", 32'(Halted), 32'h1);
        chk("oor_addr", Address, 32'h3FC);
        redirect(32'h10);
        chk("resume_halted", 32'(Halted), 32'h0);
        chk("resume_fault_sticky", 32'(Fault), 32'h1);
        chk("resume_addr", Address, 32'h10);
        tick();
        chk("resume_pc", Out_PC, 32'h10);
        chk("resume_fault_sticky2", 32'(Fault), 32'h1);
        pulse_reset();

        // Start and redirect together: redirect target wins.
        Start = 1'b1;
        redirect(32'h20);
        Start = 1'b0;
        chk("startredir_addr", Address, 32'h20);
        tick();
        chk("startredir_pc", Out_PC, 32'h20);

        // JUMP word at 0x6C with immediate 35.
        redirect(32'h6C);
        tick();
        chk("jump_head", Out_PC, 32'h6C);
        chk("jump_instr", Out_Instruction, 32'h9000_0023);
        tick();
`ifdef FETCH_EARLY_JUMP_EN
        chk("jump_next", Out_PC, 32'h8C);
`else
        chk("jump_next", Out_PC, 32'h70);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
